// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction-memory, redirect and decode-side signals of the fetch queue unit
interface fetch_queue_unit_if #(
  parameter int ADDR_W = 18
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic              booting;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output booting
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  booting
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - boot-vector fetch stage feeding a DEPTH-entry {pc, instr} queue; FETCH_PERF_EN adds perf counters
module fetch_queue_unit #(
  parameter int ADDR_W    = 18,
  parameter int DEPTH     = 4,
  parameter int BOOT_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [15:0]        perf_flushes,
`endif
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              push, pop, flush, out_valid, booting;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       target_aligned;
  logic [1:0]        unused_target_bits;

  assign target_aligned     = {bus.redirect_target[31:2], 2'b00};
  assign unused_target_bits = bus.redirect_target[1:0];
  assign out_valid          = (count_q != '0);

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.booting   = booting;
  assign bus.imem_addr = imem_addr;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    booting    = 1'b0;
    imem_addr  = fetch_pc_q[ADDR_W+1:2];
    case (state_q)
      ST_BOOT: begin
        booting   = 1'b1;
        imem_addr = ADDR_W'(BOOT_ADDR);
        state_d   = ST_RUN;
        fetch_pc_d = bus.redirect ? target_aligned : {bus.imem_data[31:2], 2'b00};
      end
      default: begin
        if (bus.redirect) begin
          flush      = 1'b1;
          fetch_pc_d = target_aligned;
        end else begin
          pop  = out_valid && bus.out_ready;
          // A full queue may still accept a word when the head leaves this cycle
          push = (count_q < FULL_CNT) || pop;
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
          instr_mem_q[wr_ptr_q] <= bus.imem_data;
          wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [15:0] perf_flushes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (flush) begin
        perf_flushes_q <= perf_flushes_q + 16'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - fetch_queue_unit bench: directed scenarios plus random traffic against a queue model
module tb_fetch_queue_unit;
  localparam int ADDR_W    = 18;
  localparam int DEPTH     = 4;
  localparam int BOOT_ADDR = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] boot_vec = 32'h0000_0100;

  fetch_queue_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flushes;
`endif

  fetch_queue_unit #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BOOT_ADDR(BOOT_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {14'h2A5, a} ^ {a[7:0], 24'h00_0000};
  endfunction

  assign bus.imem_data = (bus.imem_addr == ADDR_W'(BOOT_ADDR)) ? boot_vec : mem_word(bus.imem_addr);

  function automatic logic [31:0] mdata(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(BOOT_ADDR)) ? boot_vec : mem_word(a);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: boot flag, next fetch PC and an unbounded queue limited to DEPTH by rule
  logic        m_boot;
  logic [31:0] m_fetch;
  ent_t        mq[$];
  int unsigned m_fetched, m_flushes;

  function automatic logic [31:0] align(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_fetch = 32'h0;
    mq.delete();
    m_fetched = 0;
    m_flushes = 0;
  endtask

  task automatic model_update(input logic rd, input logic [31:0] tgt, input logic rdy);
    ent_t e;
    bit   do_pop, do_push;
    if (m_boot) begin
      m_fetch = rd ? align(tgt) : align(mdata(ADDR_W'(BOOT_ADDR)));
      m_boot  = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_fetch = align(tgt);
      m_flushes++;
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      do_push = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc    = m_fetch;
        e.instr = mdata(m_fetch[ADDR_W+1:2]);
        mq.push_back(e);
        m_fetch = m_fetch + 32'd4;
        m_fetched++;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [ADDR_W-1:0] exp_addr;
    exp_addr = m_boot ? ADDR_W'(BOOT_ADDR) : m_fetch[ADDR_W+1:2];
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("booting", 32'(bus.booting), 32'(m_boot));
    chk("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
    if (mq.size() != 0) begin
      chk("out_pc", bus.out_pc, mq[0].pc);
      chk("out_instr", bus.out_instr, mq[0].instr);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushes", 32'(perf_flushes), m_flushes & 32'hFFFF);
`endif
  endtask

  // Starts and ends at a falling edge; inputs are held across the rising edge
  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy);
    compare_outputs();
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.out_ready       = rdy;
    model_update(rd, tgt, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] vec);
    rst = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_booting", 32'(bus.booting), 32'd1);
    boot_vec = vec;
    bus.redirect = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), BOOT_ADDR);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_flushes", 32'(perf_flushes), 32'd0);
`endif
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    bus.redirect        = 1'b0;
    bus.redirect_target = 32'h0;
    bus.out_ready       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Boot and streaming
    do_reset(32'h0000_0100);
    step(1'b0, 32'h0, 1'b1);
    chk("boot_imem_addr", 32'(bus.imem_addr), 32'h40);
    chk("boot_done", 32'(bus.booting), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("boot_pc0", bus.out_pc, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    chk("boot_pc1", bus.out_pc, 32'h104);
    step(1'b0, 32'h0, 1'b1);
    chk("boot_pc2", bus.out_pc, 32'h108);

    // Backpressure, then full queue with simultaneous pop
    do_reset(32'h0000_0100);
    for (int i = 0; i < 11; i++) step(1'b0, 32'h0, 1'b0);
    chk("bp_fetch_stall", 32'(bus.imem_addr), 32'h44);
    chk("bp_head_hold", bus.out_pc, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    chk("full_pop_fetch", 32'(bus.imem_addr), 32'h45);
    chk("full_pop_head", bus.out_pc, 32'h104);
    step(1'b0, 32'h0, 1'b0);
    chk("full_no_push", 32'(bus.imem_addr), 32'h45);
    for (int i = 0; i < 5; i++) begin
      chk("bp_seq", bus.out_pc, 32'h104 + 32'(4 * i));
      step(1'b0, 32'h0, 1'b1);
    end

    // Redirect with three entries queued
    do_reset(32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0203, 1'b1);
    chk("redir_flush", 32'(bus.out_valid), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("redir_valid", 32'(bus.out_valid), 32'd1);
    chk("redir_target", bus.out_pc, 32'h200);

    // PC wrap
    do_reset(32'hFFFF_FFF8);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap0", bus.out_pc, 32'hFFFF_FFF8);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap1", bus.out_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap2", bus.out_pc, 32'h0000_0000);

    // Mid-run reset with queue non-empty, then counter scenario
    do_reset(32'h0000_0100);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0300, 1'b1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_flushes_1", 32'(perf_flushes), 32'd1);
    do_reset(32'h0000_0100);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0400, 1'b1);
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_flushes_1b", 32'(perf_flushes), 32'd1);
`endif
    do_reset(32'h0000_0100);

    // Random traffic, including redirects during boot and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom());
      end else begin
        step($urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 3) != 0);
      end
    end
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
